seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL expose clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL expose rst, input, 1, an asynchronous active-high reset.
REQ-003 The block SHALL expose start, input, 1, a request to begin a multiply, sampled on the clock edge.
REQ-004 The block SHALL expose a, input, 8, the unsigned multiplicand.
REQ-005 The block SHALL expose b, input, 8, the unsigned multiplier.
REQ-006 The block SHALL expose busy, output, 1, high while an operation is in progress.
REQ-007 The block SHALL expose done, output, 1, a one-cycle completion strobe that drives the downstream 16-bit register's load enable.
REQ-008 The block SHALL expose product, output, 16, the unsigned result, which feeds the downstream register's data input.

Function
REQ-009 The block SHALL implement an FSM with three states (IDLE, RUN, DONE) and no other reachable states.
REQ-010 In IDLE, a start=1 sample SHALL capture a and b into internal operand registers, clear the 16-bit accumulator and the 3-bit iteration counter, and move the FSM to RUN.
REQ-011 In IDLE with start=0, the FSM SHALL stay in IDLE and all outputs SHALL hold.
REQ-012 In RUN, each cycle SHALL add the multiplicand (zero-extended to 16 bits and shifted left by the counter value) to the accumulator when the current multiplier LSB is 1, then shift the multiplier right by one.
REQ-013 Every RUN cycle SHALL increment the counter, and the FSM SHALL leave RUN after exactly 8 iterations; there SHALL be no early exit when the multiplier reaches zero.
REQ-014 On the eighth RUN edge, the block SHALL load the final accumulator value into product and move the FSM to DONE.
REQ-015 done SHALL be a registered output, high for exactly the one cycle the FSM is in DONE; the FSM SHALL then return to IDLE.
REQ-016 Latency SHALL be fixed: if start is sampled at edge k, done is high in the cycle following edge k+8, and product is valid in that same cycle.
REQ-017 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-018 start SHALL be ignored in RUN and DONE; operands SHALL NOT change mid-operation even if a or b change.
REQ-019 If start is held high continuously, a new operation SHALL begin at the first IDLE edge, giving one operation every 10 cycles.
REQ-020 product SHALL change only on the completion edge (REQ-014) or on reset, and SHALL hold its last result at all other times.
REQ-021 All arithmetic SHALL be unsigned and 16 bits wide; no overflow is possible, and no carry-out is provided.

Reset
REQ-022 While rst=1, the FSM SHALL go immediately to IDLE, with busy=0, done=0, product=16'h0000, and the accumulator, counter and operand registers cleared.
REQ-023 Asserting rst mid-operation SHALL abort that operation; no done pulse SHALL be produced for it.
REQ-024 After rst is released, the first start sampled SHALL begin a fresh operation normally.

Structure
REQ-025 A shared package SHALL hold the FSM state encodings (2 bits) and the constants OP_W=8, RES_W=16 and ITER=8.
REQ-026 The design SHALL be a single module with no sub-modules; the FSM, counter and datapath are small enough to stay inline.

Verification
REQ-027 Scenario: a=3, b=5, start pulsed 1 cycle -> done high exactly 9 cycles after the start edge, product=16'h000F.
REQ-028 Scenario: a=8'hFF, b=8'hFF -> product=16'hFE01 with done; product=0 before the first done.
REQ-029 Scenario: a=8'h00, b=8'hA7 -> product=0, with done still pulsing at the same latency.
REQ-030 Scenario: start held high with a=2, b=7, then a=4, b=4 -> done pulses 10 cycles apart, products 14 then 16.
REQ-031 Scenario: start with a=9, b=9; change a/b and pulse start at cycle 3 -> a single done, product=81.
REQ-032 Scenario: start with a=6, b=6; rst at cycle 4 -> busy=0, product=0, no done; a restart with a=6, b=6 -> product=36.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared constants and FSM encoding for the 8x8 shift-add sequential multiplier.
package seq_multiplier_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;
  localparam int unsigned ITER  = 8;
  localparam int unsigned CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned 8x8 shift-add multiplier: fixed 8 RUN cycles, one-cycle done strobe,
// product held until the next completion or reset.
module seq_multiplier
  import seq_multiplier_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] product
);

  state_t             state;
  state_t             state_next;
  logic [OP_W-1:0]    mcand;
  logic [OP_W-1:0]    mplier;
  logic [RES_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [RES_W-1:0]   acc_sum;
  logic               last_iter;

  // Partial product for this iteration folded into the running sum.
  always_comb begin
    acc_sum   = acc;
    last_iter = (cnt == CNT_W'(ITER - 1));
    if (mplier[0]) begin
      acc_sum = acc + (RES_W'(mcand) << cnt);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == IDLE && start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Outputs registered from the next state so they line up with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (state == RUN && last_iter) begin
        product <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: latency, hold behaviour, back-to-back starts,
// mid-operation operand changes and reset abort.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  seq_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pulsed-start multiply; done must appear only after edge k+8.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [15:0] exp, input logic [15:0] prev, input string tag);
    a = op_a;
    b = op_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy@k"}, 16'(busy), 16'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("%s done@k+%0d", tag, i), 16'(done), 16'd0);
      check($sformatf("%s hold@k+%0d", tag, i), product, prev);
    end
    tick();
    check({tag, " done@k+8"}, 16'(done), 16'd1);
    check({tag, " busy@k+8"}, 16'(busy), 16'd1);
    check({tag, " product"}, product, exp);
    tick();
    check({tag, " done@k+9"}, 16'(done), 16'd0);
    check({tag, " busy@k+9"}, 16'(busy), 16'd0);
    check({tag, " product hold"}, product, exp);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    check("reset busy", 16'(busy), 16'd0);
    check("reset done", 16'(done), 16'd0);
    check("reset product", product, 16'h0000);
    rst = 1'b0;
    tick();
    check("idle busy", 16'(busy), 16'd0);

    run_op(8'hFF, 8'hFF, 16'hFE01, 16'h0000, "ffxff");
    run_op(8'h00, 8'hA7, 16'h0000, 16'hFE01, "0xa7");
    run_op(8'd3, 8'd5, 16'h000F, 16'h0000, "3x5");

    // Start held high: second op captured at the first IDLE edge, 10 cycles later.
    a = 8'd2;
    b = 8'd7;
    start = 1'b1;
    tick();
    a = 8'd4;
    b = 8'd4;
    for (int i = 1; i <= 19; i++) begin
      tick();
      check($sformatf("held done@k+%0d", i), 16'(done), 16'((i == 8) || (i == 18)));
      if (i == 8)  check("held product1", product, 16'd14);
      if (i == 18) begin
        check("held product2", product, 16'd16);
        start = 1'b0;
      end
    end
    tick();
    check("held idle busy", 16'(busy), 16'd0);

    // Operand change and start retrigger mid-operation are ignored.
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      if (i == 3) begin
        a = 8'd1;
        b = 8'd2;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      check($sformatf("midchg done@k+%0d", i), 16'(done), 16'(i == 8));
      if (i >= 8) check($sformatf("midchg product@k+%0d", i), product, 16'd81);
    end

    // Reset mid-operation aborts with no done.
    a = 8'd6;
    b = 8'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    check("pre-abort busy", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 16'(busy), 16'd0);
    check("abort done", 16'(done), 16'd0);
    check("abort product", product, 16'h0000);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("post-abort done@%0d", i), 16'(done), 16'd0);
      check($sformatf("post-abort busy@%0d", i), 16'(busy), 16'd0);
    end
    run_op(8'd6, 8'd6, 16'd36, 16'h0000, "6x6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
